// File: rtl/mem_stage_if.sv
// Signal bundle between the execute/memory/write-back neighbours and mem_stage.
// The stage itself uses the slave view; the surrounding pipeline (or a bench)
// uses the master view.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 161,
  parameter int MEM_TO_WB_WD = 136,
  parameter int STALL_WD     = 6
);
  logic                    flush;
  logic [STALL_WD-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id_fwd;
  logic [65:0]             mem_to_id_hilo_fwd;

  modport master (
    output flush, stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_fwd, mem_to_id_hilo_fwd
  );

  modport slave (
    input  flush, stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_fwd, mem_to_id_hilo_fwd
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute-to-memory bus, keeps
// the SRAM load word alive across stalls, forms the load result and drives
// the write-back and forwarding buses.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 161,
  parameter int MEM_TO_WB_WD = 136,
  parameter int STALL_WD     = 6
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus_if
);

  logic [EX_TO_MEM_WD-1:0] stage_reg;
  logic                    first_cycle_reg;
  logic [31:0]             rdata_buf_reg;
  logic                    buf_valid_reg;

  logic [STALL_WD-1:0] stall_vec;
  logic                stall_self;
  logic                stall_wb;

  assign stall_vec  = bus_if.stall;
  assign stall_self = stall_vec[3];
  assign stall_wb   = stall_vec[4];

  // Stage register plus the read-data hold buffer. The SRAM word is only
  // valid in the first cycle of an entry, so it is parked in rdata_buf_reg
  // if the stage is held beyond that cycle.
  always_ff @(posedge clk) begin
    if (rst || bus_if.flush) begin
      stage_reg       <= '0;
      first_cycle_reg <= 1'b0;
      rdata_buf_reg   <= '0;
      buf_valid_reg   <= 1'b0;
    end else if (stall_self && !stall_wb) begin
      // Downstream keeps moving: hand it a bubble.
      stage_reg       <= '0;
      first_cycle_reg <= 1'b0;
      buf_valid_reg   <= 1'b0;
    end else if (!stall_self) begin
      stage_reg       <= bus_if.ex_to_mem_bus;
      first_cycle_reg <= 1'b1;
      buf_valid_reg   <= 1'b0;
    end else begin
      first_cycle_reg <= 1'b0;
      if (first_cycle_reg) begin
        rdata_buf_reg <= bus_if.data_sram_rdata;
        buf_valid_reg <= 1'b1;
      end
    end
  end

  // Field extraction from the stage register.
  logic        hi_we, lo_we, sel_rf_res, rf_we;
  logic [31:0] hi_data, lo_data, pc, ex_result;
  logic [4:0]  mem_op, rf_waddr;
  logic [1:0]  off;

  assign hi_we      = stage_reg[160];
  assign lo_we      = stage_reg[159];
  assign hi_data    = stage_reg[158:127];
  assign lo_data    = stage_reg[126:95];
  assign mem_op     = stage_reg[80:76];
  assign pc         = stage_reg[75:44];
  assign sel_rf_res = stage_reg[38];
  assign rf_we      = stage_reg[37];
  assign rf_waddr   = stage_reg[36:32];
  assign ex_result  = stage_reg[31:0];
  assign off        = ex_result[1:0];

  // Live SRAM data in the first cycle, buffered copy while held.
  logic [31:0] effective_rdata;
  assign effective_rdata = first_cycle_reg ? bus_if.data_sram_rdata : rdata_buf_reg;

  // Byte lanes of the load word.
  logic [7:0] rd_byte [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign rd_byte[gi] = effective_rdata[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  assign byte_sel = rd_byte[off];
  // off[0] is ignored for halfwords; alignment is checked upstream.
  assign half_sel = off[1] ? effective_rdata[31:16] : effective_rdata[15:0];

  // One-hot load decode; anything else yields zero.
  logic [31:0] load_result;
  always_comb begin
    load_result = '0;
    case (mem_op)
      5'b10000: load_result = {{24{byte_sel[7]}}, byte_sel};
      5'b01000: load_result = {24'h0, byte_sel};
      5'b00100: load_result = {{16{half_sel[15]}}, half_sel};
      5'b00010: load_result = {16'h0, half_sel};
      5'b00001: load_result = effective_rdata;
      default:  load_result = '0;
    endcase
  end

  logic [31:0] rf_wdata;
  assign rf_wdata = sel_rf_res ? load_result : ex_result;

  logic [MEM_TO_WB_WD-1:0] wb_bus;
  assign wb_bus = {hi_we, lo_we, hi_data, lo_data, pc, rf_we, rf_waddr, rf_wdata};

  assign bus_if.mem_to_wb_bus      = wb_bus;
  assign bus_if.mem_to_id_fwd      = {rf_we, rf_waddr, rf_wdata};
  assign bus_if.mem_to_id_hilo_fwd = {hi_we, lo_we, hi_data, lo_data};

  // Fields carried on the bus that this stage does not consume.
  logic unused_bits;
  assign unused_bits = ^{stage_reg[94:81], stage_reg[43:39], stall_vec[2:0],
                         stall_vec[STALL_WD-1:5], buf_valid_reg};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors, immediate assertions.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [160:0] mk_ex(
    input logic hw, input logic lw, input logic [31:0] hd, input logic [31:0] ld,
    input logic [4:0] op, input logic [31:0] pc, input logic [3:0] wen,
    input logic sel, input logic rfwe, input logic [4:0] wa, input logic [31:0] res);
    logic en;
    en = (op != 5'd0) || (wen != 4'd0);
    return {hw, lw, hd, ld, 14'h2A5, op, pc, en, wen, sel, rfwe, wa, res};
  endfunction

  function automatic logic [135:0] mk_wb(
    input logic hw, input logic lw, input logic [31:0] hd, input logic [31:0] ld,
    input logic [31:0] pc, input logic rfwe, input logic [4:0] wa, input logic [31:0] wd);
    return {hw, lw, hd, ld, pc, rfwe, wa, wd};
  endfunction

  initial begin
    rst = 1'b1;
    ifc.flush = 1'b0;
    ifc.stall = '0;
    ifc.ex_to_mem_bus = '0;
    ifc.data_sram_rdata = '0;
    tick;
    ifc.ex_to_mem_bus = mk_ex(1, 1, 32'h1, 32'h2, 5'b00001, 32'h4, 0, 1, 1, 5'd1, 32'h0);
    tick;
    chk("reset_wb", ifc.mem_to_wb_bus, '0);
    chk("reset_fwd", 136'(ifc.mem_to_id_fwd), '0);
    chk("reset_hilo", 136'(ifc.mem_to_id_hilo_fwd), '0);
    rst = 1'b0;

    // lb, off=3
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b10000, 32'h100, 0, 1, 1, 5'd3, 32'h1003);
    tick;
    ifc.data_sram_rdata = 32'h80FF_1234;
    #1;
    chk("lb_fwd", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd3, 32'hFFFF_FF80}));
    chk("lb_wb", ifc.mem_to_wb_bus, mk_wb(0, 0, 0, 0, 32'h100, 1, 5'd3, 32'hFFFF_FF80));

    // lbu, off=3
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b01000, 32'h104, 0, 1, 1, 5'd3, 32'h1003);
    tick;
    chk("lbu_fwd", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd3, 32'h0000_0080}));

    // lh, off=2
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b00100, 32'h108, 0, 1, 1, 5'd4, 32'h1002);
    tick;
    ifc.data_sram_rdata = 32'h8001_7FFF;
    #1;
    chk("lh_fwd", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd4, 32'hFFFF_8001}));

    // lhu, off=0
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b00010, 32'h10C, 0, 1, 1, 5'd4, 32'h1000);
    tick;
    chk("lhu_off0", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd4, 32'h0000_7FFF}));

    // lhu, off=3: off[0] ignored, upper half selected
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b00010, 32'h110, 0, 1, 1, 5'd4, 32'h1003);
    tick;
    chk("lhu_off3", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd4, 32'h0000_8001}));

    // lw
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b00001, 32'h114, 0, 1, 1, 5'd6, 32'h1000);
    tick;
    chk("lw_fwd", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd6, 32'h8001_7FFF}));

    // mem_op not one-hot -> zero load result
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b00011, 32'h118, 0, 1, 1, 5'd6, 32'h1000);
    tick;
    chk("bad_op", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd6, 32'h0}));

    // ALU op
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b0, 32'h11C, 0, 0, 1, 5'd5, 32'h1234_5678);
    tick;
    chk("alu_fwd", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd5, 32'h1234_5678}));

    // store: wdata follows ex_result, rf_we unchanged
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b0, 32'h120, 4'hF, 0, 0, 5'd0, 32'hABCD_0000);
    tick;
    chk("store_wb", ifc.mem_to_wb_bus, mk_wb(0, 0, 0, 0, 32'h120, 0, 5'd0, 32'hABCD_0000));

    // mthi-style
    ifc.ex_to_mem_bus = mk_ex(1, 0, 32'hA5A5_A5A5, 32'h0, 5'b0, 32'h124, 0, 0, 0, 5'd0, 32'h0);
    tick;
    chk("mthi_we", 136'(ifc.mem_to_id_hilo_fwd[65]), 136'(1'b1));
    chk("mthi_hilo", 136'(ifc.mem_to_id_hilo_fwd), 136'({1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0}));

    // Load held for 3 cycles while SRAM data changes
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b00001, 32'h200, 0, 1, 1, 5'd7, 32'h2000);
    tick;
    ifc.data_sram_rdata = 32'h1122_3344;
    ifc.stall = 6'b011000;
    #1;
    chk("hold_c1", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd7, 32'h1122_3344}));
    ifc.ex_to_mem_bus = mk_ex(0, 0, 0, 0, 5'b01000, 32'h204, 0, 1, 1, 5'd8, 32'h2000);
    tick;
    ifc.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("hold_c2", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd7, 32'h1122_3344}));
    chk("hold_bufv", 136'(dut.buf_valid_reg), 136'(1'b1));
    tick;
    chk("hold_c3", ifc.mem_to_wb_bus, mk_wb(0, 0, 0, 0, 32'h200, 1, 5'd7, 32'h1122_3344));
    ifc.stall = '0;
    tick;
    chk("release_lbu", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd8, 32'h0000_00EF}));
    chk("release_bufv", 136'(dut.buf_valid_reg), 136'(1'b0));

    // Bubble: stall[3]=1, stall[4]=0
    ifc.ex_to_mem_bus = mk_ex(1, 1, 32'h5, 32'h6, 5'b0, 32'h300, 0, 0, 1, 5'd9, 32'h77);
    ifc.stall = 6'b001000;
    tick;
    chk("bubble_wb", ifc.mem_to_wb_bus, '0);
    chk("bubble_rfwe", 136'(ifc.mem_to_id_fwd[37]), 136'(1'b0));
    ifc.stall = '0;

    // Reset while a load is held
    ifc.ex_to_mem_bus = mk_ex(1, 0, 32'h9, 32'h0, 5'b00001, 32'h400, 0, 1, 1, 5'd9, 32'h3000);
    tick;
    ifc.data_sram_rdata = 32'hCAFE_F00D;
    ifc.stall = 6'b011000;
    tick;
    chk("rst_pre", 136'(ifc.mem_to_id_fwd), 136'({1'b1, 5'd9, 32'hCAFE_F00D}));
    rst = 1'b1;
    tick;
    chk("rst_wb", ifc.mem_to_wb_bus, '0);
    chk("rst_hilo", 136'(ifc.mem_to_id_hilo_fwd), '0);
    chk("rst_bufv", 136'(dut.buf_valid_reg), 136'(1'b0));
    chk("rst_buf", 136'(dut.rdata_buf_reg), '0);
    rst = 1'b0;
    ifc.stall = '0;

    // Flush while a load is held (flush wins over stall)
    ifc.ex_to_mem_bus = mk_ex(0, 1, 32'h0, 32'h1357_9BDF, 5'b00001, 32'h500, 0, 1, 1, 5'd10, 32'h4000);
    tick;
    ifc.data_sram_rdata = 32'h0BAD_CAFE;
    ifc.stall = 6'b011000;
    tick;
    ifc.data_sram_rdata = 32'h0;
    #1;
    chk("flush_pre", ifc.mem_to_wb_bus, mk_wb(0, 1, 32'h0, 32'h1357_9BDF, 32'h500, 1, 5'd10, 32'h0BAD_CAFE));
    ifc.flush = 1'b1;
    tick;
    chk("flush_fwd", 136'(ifc.mem_to_id_fwd), '0);
    chk("flush_hilo", 136'(ifc.mem_to_id_hilo_fwd), '0);
    chk("flush_bufv", 136'(dut.buf_valid_reg), 136'(1'b0));
    ifc.flush = 1'b0;
    ifc.stall = '0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
